// File: rtl/dadda_prod_accumulator.sv
// ---------------------------------------------------------------------------
// dadda_prod_accumulator
//
// Sums a run of 32-bit unsigned products coming from the 16x16 Dadda
// multiplier's final carry-propagate adder into an ACC_W-bit running sum.
// Products come in under a valid/ready handshake, one per cycle. The
// finished sum goes out under a second valid/ready handshake.
//
// Optional feature macro: DADDA_ACC_SAT_EN
//   defined   - on overflow the accumulator clamps to 2^ACC_W-1 and stays
//               clamped for the rest of the run
//   undefined - the accumulator wraps modulo 2^ACC_W
//   In both builds ovf is a sticky flag for the current run.
//
// Parameters
//   ACC_W     accumulator width (>= 33)
//   LEN_W     run-length field width
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a run (sampled only in IDLE)
//   len        in   number of products in the run, latched on start
//   in_valid   in   prod is valid
//   in_ready   out  block accepts prod this cycle (state ACC)
//   prod       in   32-bit unsigned product
//   out_valid  out  acc_out holds the completed sum (state DONE)
//   out_ready  in   downstream consumes the result
//   acc_out    out  accumulator value
//   ovf        out  sticky overflow flag for the current run
//   busy       out  state is not IDLE
// ---------------------------------------------------------------------------
module dadda_prod_accumulator #(
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [ACC_W-1:0] acc_p1;
    logic             ovf_p1;

    logic             accept;
    logic             last;
    logic [ACC_W:0]   sum_p0;
    logic [ACC_W-1:0] acc_nxt;

`ifdef DADDA_ACC_SAT_EN
    // Once the run has overflowed the result is pinned at full scale, even
    // if later products are zero.
    function automatic logic [ACC_W-1:0] fold_sum(input logic [ACC_W:0] s,
                                                  input logic sticky);
        if (s[ACC_W] || sticky)
            fold_sum = {ACC_W{1'b1}};
        else
            fold_sum = s[ACC_W-1:0];
    endfunction
`else
    // Dropping the carry bit gives modulo-2^ACC_W wraparound.
    function automatic logic [ACC_W-1:0] fold_sum(input logic [ACC_W:0] s);
        fold_sum = s[ACC_W-1:0];
    endfunction
`endif

    assign accept = in_valid && (state == ACC);
    assign last   = (cnt == (len_q - LEN_W'(1)));

    // Stage p0: one-bit-wider add so the carry out of bit ACC_W-1 is visible
    assign sum_p0 = {1'b0, acc_p1} + {{(ACC_W - 31){1'b0}}, prod};

`ifdef DADDA_ACC_SAT_EN
    assign acc_nxt = fold_sum(sum_p0, ovf_p1);
`else
    assign acc_nxt = fold_sum(sum_p0);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = (len != '0) ? ACC : DONE;
            end
            ACC: begin
                if (accept && last)
                    state_nxt = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p1: state, counters and the running sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            len_q  <= '0;
            cnt    <= '0;
            acc_p1 <= '0;
            ovf_p1 <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q  <= len;
                        cnt    <= '0;
                        acc_p1 <= '0;
                        ovf_p1 <= 1'b0;
                    end
                end
                ACC: begin
                    if (accept) begin
                        cnt    <= cnt + LEN_W'(1);
                        acc_p1 <= acc_nxt;
                        if (sum_p0[ACC_W])
                            ovf_p1 <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // All outputs come straight from registers or decoded registered state.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign acc_out   = acc_p1;
    assign ovf       = ovf_p1;

endmodule

// File: tb/tb_dadda_prod_accumulator.sv
module tb_dadda_prod_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        in_valid = 1'b0;
    logic [31:0] prod = 32'd0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, ovf_a, busy_a;
    logic [39:0] acc_a;
    logic        in_ready_b, out_valid_b, ovf_b, busy_b;
    logic [32:0] acc_b;

    int vectors = 0;
    int miscompares = 0;

`ifdef DADDA_ACC_SAT_EN
    localparam logic [63:0] B_STALL = 64'h1_FFFF_FFFF;
    localparam logic [63:0] B_OVF3  = 64'h1_FFFF_FFFF;
`else
    localparam logic [63:0] B_STALL = 64'h1_FFFF_FFFC;
    localparam logic [63:0] B_OVF3  = 64'h0_FFFF_FFFD;
`endif

    always #5 clk = ~clk;

    dadda_prod_accumulator #(.ACC_W(40), .LEN_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready_a), .prod(prod),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .acc_out(acc_a), .ovf(ovf_a), .busy(busy_a)
    );

    dadda_prod_accumulator #(.ACC_W(33), .LEN_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready_b), .prod(prod),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .acc_out(acc_b), .ovf(ovf_b), .busy(busy_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ctrl_a(input string tag, input logic ir, input logic ov,
                          input logic bz);
        check({tag, "_in_ready"},  {63'd0, in_ready_a},  {63'd0, ir});
        check({tag, "_out_valid"}, {63'd0, out_valid_a}, {63'd0, ov});
        check({tag, "_busy"},      {63'd0, busy_a},      {63'd0, bz});
    endtask

    initial begin
        // reset state
        tick();
        tick();
        ctrl_a("rst", 1'b0, 1'b0, 1'b0);
        check("rst_acc", {24'd0, acc_a}, 64'd0);
        check("rst_ovf", {63'd0, ovf_a}, 64'd0);
        rst_n = 1'b1;
        tick();

        // basic run: 1+2+3
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        ctrl_a("basic_start", 1'b1, 1'b0, 1'b1);
        in_valid = 1'b1; prod = 32'd1;
        tick();
        prod = 32'd2;
        tick();
        check("basic_mid_acc", {24'd0, acc_a}, 64'd3);
        prod = 32'd3;
        tick();
        in_valid = 1'b0;
        ctrl_a("basic_done", 1'b0, 1'b1, 1'b1);
        check("basic_acc", {24'd0, acc_a}, 64'd6);
        check("basic_ovf", {63'd0, ovf_a}, 64'd0);
        // start while DONE is ignored
        start = 1'b1; len = 8'd7;
        tick();
        start = 1'b0;
        ctrl_a("done_start", 1'b0, 1'b1, 1'b1);
        check("done_start_acc", {24'd0, acc_a}, 64'd6);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        ctrl_a("basic_idle", 1'b0, 1'b0, 1'b0);
        check("basic_hold_acc", {24'd0, acc_a}, 64'd6);

        // empty run; prod offered while in DONE must not be consumed
        start = 1'b1; len = 8'd0; in_valid = 1'b1; prod = 32'd5;
        tick();
        start = 1'b0;
        ctrl_a("empty_done", 1'b0, 1'b1, 1'b1);
        check("empty_acc", {24'd0, acc_a}, 64'd0);
        tick();
        check("empty_acc2", {24'd0, acc_a}, 64'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        ctrl_a("empty_idle", 1'b0, 1'b0, 1'b0);

        // four max products with 2-cycle gaps; a start during ACC is ignored
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; prod = 32'hFFFF_FFFF;
            tick();
            in_valid = 1'b0;
            if (i == 1) begin
                start = 1'b1; len = 8'd1;
            end
            tick();
            start = 1'b0;
            if (i == 1) begin
                ctrl_a("acc_start", 1'b1, 1'b0, 1'b1);
                check("stall_mid_acc", {24'd0, acc_a}, 64'h1_FFFF_FFFE);
            end
            tick();
        end
        ctrl_a("stall_done", 1'b0, 1'b1, 1'b1);
        check("stall_acc_a", {24'd0, acc_a}, 64'h3_FFFF_FFFC);
        check("stall_ovf_a", {63'd0, ovf_a}, 64'd0);
        check("stall_acc_b", {31'd0, acc_b}, B_STALL);
        check("stall_ovf_b", {63'd0, ovf_b}, 64'd1);
        // backpressure: result held stable
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_acc", {24'd0, acc_a}, 64'h3_FFFF_FFFC);
            check("bp_valid", {63'd0, out_valid_a}, 64'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        ctrl_a("bp_idle", 1'b0, 1'b0, 1'b0);

        // overflow on the 33-bit instance
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        in_valid = 1'b1; prod = 32'hFFFF_FFFF;
        tick();
        check("ovf_first_b", {63'd0, ovf_b}, 64'd0);
        tick();
        tick();
        in_valid = 1'b0;
        check("ovf_valid_b", {63'd0, out_valid_b}, 64'd1);
        check("ovf_flag_b", {63'd0, ovf_b}, 64'd1);
        check("ovf_acc_b", {31'd0, acc_b}, B_OVF3);
        check("ovf_acc_a", {24'd0, acc_a}, 64'h2_FFFF_FFFD);
        check("ovf_flag_a", {63'd0, ovf_a}, 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // reset mid-run aborts
        start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0;
        in_valid = 1'b1; prod = 32'd100;
        tick();
        tick();
        in_valid = 1'b0;
        check("mid_acc", {24'd0, acc_a}, 64'd200);
        rst_n = 1'b0;
        #1;
        ctrl_a("async_rst", 1'b0, 1'b0, 1'b0);
        check("async_rst_acc", {24'd0, acc_a}, 64'd0);
        check("async_rst_ovf_b", {63'd0, ovf_b}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        ctrl_a("post_rst", 1'b0, 1'b0, 1'b0);
        start = 1'b1; len = 8'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; prod = 32'd7;
        tick();
        in_valid = 1'b0;
        ctrl_a("rerun_done", 1'b0, 1'b1, 1'b1);
        check("rerun_acc", {24'd0, acc_a}, 64'd7);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        ctrl_a("rerun_idle", 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dadda_prod_accumulator.md
# dadda_prod_accumulator

Accumulates a run of 32-bit unsigned products from the 16x16 Dadda multiplier's final carry-propagate adder into a wide running sum. It sits directly downstream of the final adder. The carry-propagate result is assembled with the pass-through LSB and the carry-out into `prod[31:0]` before it enters this block. Products are accepted under a valid/ready handshake, one per cycle, and the completed sum is presented under a second valid/ready handshake.

## Interface
- `ACC_W`, 40: accumulator width in bits. Must be at least 33.
- `LEN_W`, 8: width of the run-length field.

- `clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: begin a run. Sampled only in IDLE.
- `len`, in, LEN_W: number of products in the run. Latched on an accepted `start`.
- `in_valid`, in, 1: `prod` is valid.
- `in_ready`, out, 1: block accepts `prod` this cycle.
- `prod`, in, 32: unsigned product from the final adder.
- `out_valid`, out, 1: `acc_out` holds the completed run sum.
- `out_ready`, in, 1: downstream consumes the result.
- `acc_out`, out, ACC_W: accumulator value.
- `ovf`, out, 1: sticky overflow flag for the current run.
- `busy`, out, 1: high whenever state is not IDLE.

## Operation
- States:
  - IDLE: `in_ready`=0, `out_valid`=0.
  - ACC: `in_ready`=1.
  - DONE: `out_valid`=1.
- IDLE behaviour:
  - `start`=1 with `len`≠0: latch `len`, clear the accumulator, clear `ovf`, clear the counter, go to ACC.
  - `start`=1 with `len`=0: clear the accumulator and `ovf`, go straight to DONE.
- ACC behaviour:
  - Each `in_valid`&&`in_ready` edge adds `prod`, zero-extended to ACC_W, into the accumulator and increments the counter.
  - On the accept where the counter equals latched `len`−1, go to DONE. The final product is included in the sum.
- DONE behaviour:
  - `acc_out` and `ovf` are held stable.
  - `out_valid`&&`out_ready` returns the block to IDLE. The accumulator keeps its value until the next `start`.
- `start` is ignored outside IDLE. `in_valid` is ignored outside ACC; no product is consumed.
- Arithmetic:
  - The sum is ACC_W+1 bits wide internally.
  - A carry out of bit ACC_W−1 sets `ovf`, which stays set until the next accepted `start` or reset.
  - Without saturation the accumulator wraps modulo 2^ACC_W (see Configuration).
- `len` is unsigned. The maximum run is 2^LEN_W−1 products.

## Timing
- Reset (asynchronous assert, synchronous release inside the flops):
  - State = IDLE.
  - `acc_out`=0, `ovf`=0, `in_ready`=0, `out_valid`=0, `busy`=0.
  - Counter and latched `len` are cleared.
- Reset asserted mid-run aborts the run immediately, with no partial result and no `out_valid`.
- All outputs are driven from registers or decoded from registered state. There is no combinational path from any input to any output.
- Accepted `start` at edge N: `in_ready`=1 and `busy`=1 from cycle N+1.
- Throughput is one product per cycle in ACC. `in_valid` gaps stall the run without changing the accumulator.
- Final product accepted at edge M: `out_valid`=1 and `in_ready`=0 in cycle M+1, and `acc_out` already includes that product.
- `len`=0 start at edge N: `out_valid`=1 in cycle N+1 with `acc_out`=0.
- Result handoff at edge K: `out_valid`=0 in cycle K+1. A new `start` is accepted at edge K+1 at the earliest, giving one idle cycle between runs.

## Configuration
- Macro `DADDA_ACC_SAT_EN`:
  - Defined: on overflow the accumulator clamps to 2^ACC_W−1 and stays clamped for the rest of the run. `ovf` is set.
  - Undefined: the accumulator wraps modulo 2^ACC_W. `ovf` is still set.

## Test plan
- Basic run: `len`=3, products 1, 2, 3 back-to-back → `out_valid` one cycle after the third accept, `acc_out`=6, `ovf`=0.
- Empty run: `len`=0 → `out_valid` the next cycle, `acc_out`=0; `in_valid`=1 with `prod`=5 is not consumed.
- Input stalls and backpressure:
  - `len`=4, four products of 0xFFFF_FFFF with `in_valid` gaps of 2 cycles → `acc_out`=0x3_FFFF_FFFC.
  - Hold `out_ready`=0 for 5 cycles → `acc_out` stable throughout; then `out_ready`=1 → IDLE next cycle.
- Overflow with ACC_W=33: `len`=3, three products of 0xFFFF_FFFF → `ovf`=1.
  - Without the macro: `acc_out`=0x0_FFFF_FFFD.
  - With `DADDA_ACC_SAT_EN`: `acc_out`=0x1_FFFF_FFFF.
- Reset mid-run: assert `rst_n`=0 after 2 of `len`=5 products → all outputs 0 and state IDLE; a new run with `len`=1 and `prod`=7 then gives `acc_out`=7.
- `start` asserted during ACC and during DONE → ignored; latched `len` and the sum are unchanged.
